regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Arbitrates the register file's single write port among NREQ writeback requesters (ALU, LSU, CSR) using round-robin valid/ready handshakes. It registers the winning write onto the register-file write port. It also keeps a busy scoreboard of destination registers with an outstanding write, which the decode stage uses for RAW hazard stalls. It sits between the execute/memory units and RegFile.

## Interface
- NREQ, 3, number of writeback requesters
- XLEN, 32, data width
- NREG, 32, architectural register count; address width is 5
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NREQ  requester i holds a pending write
- req_ready  out  NREQ  requester i is granted this cycle; a handshake occurs when valid and ready are both high
- req_waddr  in  NREQ*5  destination register, packed, requester i at [5i+4:5i]
- req_wdata  in  NREQ*XLEN  write data, packed
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  5  destination of the issued instruction
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- busy  out  NREG  bit r set means register r has an outstanding write

## Operation
- Arbitration is combinational round-robin. Search starts at last_grant+1 and wraps modulo NREQ.
- At most one req_ready bit is high per cycle. req_ready[i] is never high unless req_valid[i] is high.
- req_ready may depend combinationally on req_valid. Requesters hold valid, waddr and wdata stable until the handshake.
- last_grant updates to the winner only on a handshake cycle. With no handshake, it holds.
- On a handshake edge, rf_waddr and rf_wdata load the winner's address and data. rf_wen loads 1 if waddr != 0, else 0.
- With no handshake, rf_wen loads 0 and rf_waddr/rf_wdata hold their values.
- Writes to x0 are accepted (the requester is drained) but never reach the register file.
- Scoreboard set: issue_valid with issue_rd != 0 sets busy[issue_rd] at the edge. issue_rd == 0 is ignored, so busy[0] is always 0.
- Scoreboard clear: at an edge where rf_wen is currently 1, busy[rf_waddr] clears. This is the same edge at which RegFile commits the data.
- A set and a clear of the same register on the same edge: the set wins (a newer producer is outstanding).
- A clear of a register whose busy bit is already 0 is harmless.
- No ordering is kept between requesters writing the same register. Decode must not issue a second writer to a busy rd.

## Timing
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0
  - busy=0
  - last_grant=NREQ-1, so requester 0 has first priority after reset
  - req_ready follows the combinational arbitration of the current inputs
- Latency: handshake at edge N, then rf_wen high during cycle N+1, then data visible in RegFile after edge N+1 and busy cleared after edge N+1.
- Throughput: one write per cycle sustained. Back-to-back grants to the same requester are allowed only when no other requester is valid.
- Starvation bound: a continuously valid requester is granted within NREQ cycles.
- Reset mid-operation: an accepted write still held in the output register is dropped (rf_wen forced to 0). All busy bits are cleared. Upstream must also be reset.

## Structure
- Shared package rf_pkg:
  - XLEN, NREG, REG_ADDR_W=5
  - requester indices REQ_ALU=0, REQ_LSU=1, REQ_CSR=2
  - packed struct wb_req_t containing waddr and wdata
- One sub-module, rr_arbiter (NREQ-wide):
  - inputs: request vector and last_grant pointer
  - outputs: one-hot grant and encoded index
- The scoreboard and output register stay in the top module.

## Test plan
- Single ALU write: req_valid=001, waddr=5, wdata=0xDEADBEEF, issue of rd=5 one cycle earlier. Expect: req_ready=001 the same cycle; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF the next cycle; busy[5] goes 1→0 after that edge.
- Round-robin: all three requesters valid for 6 cycles, right after reset. Expect grant order 0,1,2,0,1,2; rf_wen high for 6 consecutive cycles.
- x0 write: LSU valid, waddr=0, wdata=0x1234. Expect: req_ready=010; rf_wen stays 0; busy unchanged; busy[0] stays 0 even when issue_rd=0 with issue_valid=1.
- Set/clear collision: busy[7]=1 with rf_wen=1, rf_waddr=7, and issue_valid=1, issue_rd=7 on the same edge. Expect busy[7] remains 1.
- Reset mid-operation: assert reset asynchronously while rf_wen=1 and busy=0x0000_00A0. Expect rf_wen=0, busy=0 immediately. After release, requester 0 wins first when all are valid.
- Hold/stability: CSR valid while ALU is continuously valid. Expect CSR granted within 3 cycles and its data unchanged at grant.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: widths, requester indices and the
// writeback request payload.
package rf_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned N_REQ      = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_CSR = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past last_i and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] req_sel;

  // Requesters above the last winner take priority; otherwise wrap to the bottom.
  always_comb begin
    mask_hi = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask_hi[i] = (IDX_W'(i) > last_i);
    end
  end

  assign req_hi  = req_i & mask_hi;
  assign req_sel = (|req_hi) ? req_hi : req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_sel[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin among writeback requesters,
// registered write port, and a busy scoreboard for decode RAW stalls.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = N_REQ
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*REG_ADDR_W-1:0] req_waddr_i,
  input  logic [NREQ*XLEN-1:0]       req_wdata_i,
  input  logic                       issue_valid_i,
  input  logic [REG_ADDR_W-1:0]      issue_rd_i,
  output logic                       rf_wen_o,
  output logic [REG_ADDR_W-1:0]      rf_waddr_o,
  output logic [XLEN-1:0]            rf_wdata_o,
  output logic [NREG-1:0]            busy_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  hs;
  wb_req_t               win;

  logic [IDX_W-1:0]      last_q,     last_d;
  logic                  rf_wen_q,   rf_wen_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q,     busy_d;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign hs          = |gnt;

  // Select the granted requester's payload; grant is one-hot or zero.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win.waddr = req_waddr_i[i*REG_ADDR_W +: REG_ADDR_W];
        win.wdata = req_wdata_i[i*XLEN +: XLEN];
      end
    end
  end

  // Write-port register and round-robin pointer advance only on a handshake.
  always_comb begin
    last_d     = last_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (hs) begin
      last_d     = gnt_idx;
      rf_wen_d   = (win.waddr != '0);
      rf_waddr_d = win.waddr;
      rf_wdata_d = win.wdata;
    end
  end

  // Clear on commit, then set on issue so a newer producer overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= IDX_W'(NREQ - 1);
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen_o   = rf_wen_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue and a
// monitor compares them against the register-file port whenever rf_wen is high.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int unsigned NR = N_REQ;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NR-1:0]            req_valid = '0;
  logic [NR-1:0]            req_ready;
  logic [NR*REG_ADDR_W-1:0] req_waddr = '0;
  logic [NR*XLEN-1:0]       req_wdata = '0;
  logic                     issue_valid = 1'b0;
  logic [REG_ADDR_W-1:0]    issue_rd = '0;
  logic                     rf_wen;
  logic [REG_ADDR_W-1:0]    rf_waddr;
  logic [XLEN-1:0]          rf_wdata;
  logic [NREG-1:0]          busy;

  int errors = 0;
  int checks = 0;
  wb_req_t exp_q[$];

  regfile_wb_arbiter #(.NREQ(NR)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_waddr_i   (req_waddr),
    .req_wdata_i   (req_wdata),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rf_wen_o      (rf_wen),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    req_waddr[i*REG_ADDR_W +: REG_ADDR_W] = a;
    req_wdata[i*XLEN +: XLEN]             = d;
  endtask

  task automatic push_exp(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    wb_req_t e;
    e.waddr = a;
    e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    wb_req_t e;
    if (!rst && rf_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h, none expected at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_waddr", 64'(rf_waddr), 64'(e.waddr));
        chk("wb_wdata", 64'(rf_wdata), 64'(e.wdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] rr_exp [6];
    int got;
    int got_cyc;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state
    @(negedge clk);
    chk("reset_rf_wen",    64'(rf_wen),    64'd0);
    chk("reset_rf_waddr",  64'(rf_waddr),  64'd0);
    chk("reset_rf_wdata",  64'(rf_wdata),  64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;

    // Single ALU write, rd=5 issued one cycle earlier
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    push_exp(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_ready",        64'(req_ready), 64'b001);
    chk("alu_busy5_set",    64'(busy[5]),   64'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("alu_wen",          64'(rf_wen),    64'd1);
    chk("alu_busy5_held",   64'(busy[5]),   64'd1);
    step();
    @(negedge clk);
    chk("alu_busy5_clear",  64'(busy),      64'd0);

    // Round-robin right after reset: order 0,1,2,0,1,2
    rst = 1'b1; #1; rst = 1'b0;
    step();
    set_req(REQ_ALU, 5'd1, 32'hA000_0001);
    set_req(REQ_LSU, 5'd2, 32'hB000_0002);
    set_req(REQ_CSR, 5'd3, 32'hC000_0003);
    req_valid = 3'b111;
    for (int r = 0; r < 2; r++) begin
      push_exp(5'd1, 32'hA000_0001);
      push_exp(5'd2, 32'hB000_0002);
      push_exp(5'd3, 32'hC000_0003);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(rr_exp[k]));
      if (k > 0) chk($sformatf("rr_wen_%0d", k), 64'(rf_wen), 64'd1);
      step();
    end
    req_valid = '0;

    // x0 write from LSU, plus an issue to x0
    set_req(REQ_LSU, 5'd0, 32'h0000_1234);
    req_valid = 3'b010;
    issue_valid = 1'b1; issue_rd = 5'd0;
    @(negedge clk);
    chk("x0_ready",  64'(req_ready), 64'b010);
    step();
    req_valid = '0; issue_valid = 1'b0;
    @(negedge clk);
    chk("x0_wen",    64'(rf_wen),   64'd0);
    chk("x0_waddr",  64'(rf_waddr), 64'd0);
    chk("x0_wdata",  64'(rf_wdata), 64'h1234);
    chk("x0_busy",   64'(busy),     64'd0);

    // Set/clear collision on register 7
    step();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    set_req(REQ_ALU, 5'd7, 32'h7777_7777);
    req_valid = 3'b001;
    push_exp(5'd7, 32'h7777_7777);
    @(negedge clk);
    chk("coll_busy7_pre", 64'(busy[7]), 64'd1);
    step();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    chk("coll_wen",       64'(rf_wen),  64'd1);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("coll_busy7_kept", 64'(busy),   64'h0000_0080);

    // Reset mid-operation with rf_wen=1 and busy=0xA0
    step();
    issue_valid = 1'b1; issue_rd = 5'd5;
    set_req(REQ_ALU, 5'd9, 32'h9999_0000);
    req_valid = 3'b001;
    push_exp(5'd9, 32'h9999_0000);
    step();
    issue_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("midrst_busy_pre", 64'(busy),   64'h0000_00A0);
    chk("midrst_wen_pre",  64'(rf_wen), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wen",      64'(rf_wen), 64'd0);
    chk("midrst_busy",     64'(busy),   64'd0);
    step();
    rst = 1'b0;
    set_req(REQ_ALU, 5'd12, 32'h1200_0012);
    set_req(REQ_LSU, 5'd13, 32'h1300_0013);
    set_req(REQ_CSR, 5'd14, 32'h1400_0014);
    req_valid = 3'b111;
    push_exp(5'd12, 32'h1200_0012);
    @(negedge clk);
    chk("postrst_first", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    @(negedge clk);

    // CSR must be granted within 3 cycles while ALU stays valid
    step();
    rst = 1'b1; #1; rst = 1'b0;
    set_req(REQ_ALU, 5'd10, 32'hAAAA_0010);
    set_req(REQ_CSR, 5'd11, 32'hCCCC_0011);
    req_valid = 3'b101;
    push_exp(5'd10, 32'hAAAA_0010);
    push_exp(5'd11, 32'hCCCC_0011);
    got = 0;
    got_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_ready[REQ_CSR]) begin
        got = 1;
        got_cyc = k;
        break;
      end
    end
    step();
    req_valid = '0;
    chk("csr_within_3",  64'(got),     64'd1);
    chk("csr_grant_cyc", 64'(got_cyc), 64'd1);

    repeat (3) step();
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
